// File: rtl/seg_scan_ctrl.sv
// Multi-digit 7-segment scan controller: double-buffered BCD load, per-slot
// dead time, leading-zero and invalid-digit blanking, one shared decoder nibble.
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [4*DIGITS-1:0]   load_data_i,
    input  logic [DIGITS-1:0]     load_dp_i,
    input  logic                  lz_en_i,
    output logic [3:0]            bcd_o,
    output logic [DIGITS-1:0]     dig_en_o,
    output logic                  dp_o,
    output logic                  frame_tick_o,
    output logic                  err_o
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK - 1);

    typedef enum logic {S_BLANK, S_SHOW} state_t;

    state_t                   state_q, state_d;
    logic [DIGITS-1:0][3:0]   active_q, active_d, shadow_q, shadow_d;
    logic [DIGITS-1:0]        active_dp_q, active_dp_d, shadow_dp_q, shadow_dp_d;
    logic                     pending_q, pending_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     lz_q;

    logic                     accept, slot_end, frame_end, in_bad, run;
    logic [DIGITS-1:0]        hidden;

    assign load_ready_o = ~pending_q;
    assign accept       = load_valid_i & ~pending_q;
    assign slot_end     = (cnt_q == CNT_LAST);
    assign frame_end    = slot_end && (idx_q == IDX_LAST);

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            in_bad = in_bad | (load_data_i[4*i +: 4] > 4'd9);
    end

    // Zero suppression walks down from the top digit; digit 0 is always eligible.
    always_comb begin
        hidden = '0;
        run    = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run       = run & (active_q[i] == 4'd0);
            hidden[i] = (active_q[i] > 4'd9) | ((i > 0) & lz_q & run);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;
        err_d       = err_q;
        case (state_q)
            S_BLANK: if (cnt_q == BLK_LAST) state_d = S_SHOW;
            S_SHOW:  if (slot_end)          state_d = S_BLANK;
            default: state_d = S_BLANK;
        endcase
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (accept) begin
            shadow_d    = load_data_i;
            shadow_dp_d = load_dp_i;
            pending_d   = 1'b1;
            err_d       = err_q | in_bad;
        end else if (frame_end && pending_q) begin
            active_d    = shadow_q;
            active_dp_d = shadow_dp_q;
            pending_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            active_q    <= '0;
            active_dp_q <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
            lz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            lz_q        <= lz_en_i;
        end
    end

    always_comb begin
        dig_en_o = '1;
        dp_o     = 1'b1;
        if (state_q == S_SHOW && !hidden[idx_q]) begin
            dig_en_o[idx_q] = 1'b0;
            dp_o            = ~active_dp_q[idx_q];
        end
    end

    assign bcd_o        = active_q[idx_q];
    assign frame_tick_o = frame_end;
    assign err_o        = err_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, PRESCALE=8, BLANK=2 (32-cycle frames).
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst, load_valid, load_ready, lz_en, dp, frame_tick, err;
    logic [15:0] load_data;
    logic [3:0]  load_dp, bcd, dig_en;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(4), .PRESCALE(8), .BLANK(2)) dut (
        .clk_i(clk), .rst_i(rst), .load_valid_i(load_valid), .load_ready_o(load_ready),
        .load_data_i(load_data), .load_dp_i(load_dp), .lz_en_i(lz_en), .bcd_o(bcd),
        .dig_en_o(dig_en), .dp_o(dp), .frame_tick_o(frame_tick), .err_o(err)
    );

    task automatic chk(input string tag, input int c, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s c=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    // Walks ncyc cycles of a frame starting at slot 0 / cycle 0, checking every output.
    // show/dpm: per-digit anode-visible and dp-on masks; optional load offered at ld_at.
    task automatic run_frame(input logic [15:0] exp_bcd, input logic [3:0] show,
                             input logic [3:0] dpm, input int ld_at, input logic [15:0] ld_val,
                             input logic [3:0] ld_dp, input logic err0, input logic err1,
                             input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int          slot, sc;
            logic        on, after;
            logic [3:0]  en_exp, nib;
            slot   = c / 8;
            sc     = c % 8;
            on     = (sc >= 2) && show[slot];
            after  = (ld_at >= 0) && (c > ld_at);
            en_exp = 4'hF;
            if (on) en_exp[slot] = 1'b0;
            nib    = exp_bcd[slot*4 +: 4];
            chk("dig_en", c, {12'h0, dig_en}, {12'h0, en_exp});
            chk("bcd", c, {12'h0, bcd}, {12'h0, nib});
            chk("dp", c, {15'h0, dp}, {15'h0, ~(on & dpm[slot])});
            chk("frame_tick", c, {15'h0, frame_tick}, {15'h0, c == 31});
            chk("load_ready", c, {15'h0, load_ready}, {15'h0, ~after});
            chk("err", c, {15'h0, err}, {15'h0, after ? err1 : err0});
            load_valid = (c == ld_at);
            load_data  = (c == ld_at) ? ld_val : 16'hFFFF;
            load_dp    = (c == ld_at) ? ld_dp : 4'hF;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_data = '0; load_dp = '0; lz_en = 1'b0;
        @(posedge clk); #1;
        chk("rst_bcd", -1, {12'h0, bcd}, 16'h0);
        chk("rst_dig_en", -1, {12'h0, dig_en}, 16'hF);
        chk("rst_dp", -1, {15'h0, dp}, 16'h1);
        chk("rst_tick", -1, {15'h0, frame_tick}, 16'h0);
        chk("rst_ready", -1, {15'h0, load_ready}, 16'h1);
        chk("rst_err", -1, {15'h0, err}, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Frame 0: zeros on all digits, load 1234 at cycle 5
        run_frame(16'h0000, 4'b1111, 4'b0000, 5, 16'h1234, 4'b0000, 1'b0, 1'b0, 32);
        lz_en = 1'b1;
        run_frame(16'h1234, 4'b1111, 4'b0000, 8, 16'h0050, 4'b0000, 1'b0, 1'b0, 32);
        run_frame(16'h0050, 4'b0011, 4'b0000, 3, 16'h0000, 4'b0000, 1'b0, 1'b0, 32);
        run_frame(16'h0000, 4'b0001, 4'b0000, 10, 16'h12A4, 4'b0100, 1'b0, 1'b1, 32);
        run_frame(16'h12A4, 4'b1101, 4'b0100, 2, 16'h5678, 4'b0000, 1'b1, 1'b1, 32);
        // Pending 9999 is discarded by the reset at cycle 20
        run_frame(16'h5678, 4'b1111, 4'b0000, 4, 16'h9999, 4'b0000, 1'b1, 1'b1, 20);
        rst = 1'b1; lz_en = 1'b0; load_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(16'h0000, 4'b1111, 4'b0000, -1, 16'h0000, 4'b0000, 1'b0, 1'b0, 32);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
